// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ==== uart_pkg : shared FSM encodings, default bit period and uio pin map; UART_PARITY_EN adds PARITY states ====
// ==== Revision 1.0 ====
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int CNT_W                = 12;

  localparam int BTN_BIT      = 0;
  localparam int SW_BIT       = 1;
  localparam int RXD_BIT      = 2;
  localparam int TXD_BIT      = 3;
  localparam int RX_VALID_BIT = 4;
  localparam int TX_BUSY_BIT  = 5;
  localparam int RX_FERR_BIT  = 6;

  localparam logic [7:0] UIO_OE_MASK = 8'b0111_1000;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ==== uart_rx : 8N1 receiver with mid-bit sampling, glitch reject and sticky framing error (UART_PARITY_EN: even parity) ====
// ==== Revision 1.0 ====
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shreg, shreg_d, data_d;
  logic             valid_d, frame_err_d;
  logic             rxd_prev;
  logic             stop_ok;
`ifdef UART_PARITY_EN
  logic             par_ok, par_ok_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      rxd_prev  <= 1'b1;
`ifdef UART_PARITY_EN
      par_ok    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      rxd_prev  <= rxd;
`ifdef UART_PARITY_EN
      par_ok    <= par_ok_d;
`endif
    end
  end

`ifdef UART_PARITY_EN
  assign stop_ok = rxd & par_ok;
`else
  assign stop_ok = rxd;
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    data_d      = data;
    valid_d     = 1'b0;
    frame_err_d = frame_err;
`ifdef UART_PARITY_EN
    par_ok_d    = par_ok;
`endif
    case (state)
      // A line held low after a bad stop bit produces no falling edge, so re-arm waits for high.
      RX_IDLE: begin
        cnt_d = '0;
        if (rxd_prev && !rxd) state_d = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rxd, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_d    = '0;
          par_ok_d = (rxd == even_parity(shreg));
          state_d  = RX_STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (stop_ok) begin
            data_d      = shreg;
            valid_d     = 1'b1;
            frame_err_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tt_um_uart_transciver.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tt_um_uart_transciver : UART TX FSM, input synchronizers, uio pin map and uart_rx (UART_PARITY_EN: even parity) ====
// ==== Revision 1.0 ====
module tt_um_uart_transciver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       btn_sync, sw_sync, rxd_sync;
  logic             btn_prev;
  logic             btn_rise, sw_on, rxd;

  tx_state_t        tx_state, tx_state_d;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]       tx_bit, tx_bit_d;
  logic [7:0]       tx_data, tx_data_d;
  logic             tx_bit_done;
  logic             txd, tx_busy;

  logic [7:0]       rx_data;
  logic             rx_valid, rx_frame_err;
  logic             unused_inputs;

  assign unused_inputs = &{1'b0, ena, uio_in[7:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b00;
      sw_sync  <= 2'b00;
      rxd_sync <= 2'b11;
      btn_prev <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], uio_in[BTN_BIT]};
      sw_sync  <= {sw_sync[0],  uio_in[SW_BIT]};
      rxd_sync <= {rxd_sync[0], uio_in[RXD_BIT]};
      btn_prev <= btn_sync[1];
    end
  end

  assign btn_rise = btn_sync[1] & ~btn_prev;
  assign sw_on    = sw_sync[1];
  assign rxd      = rxd_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_data  <= '0;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_data  <= tx_data_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state;
    tx_cnt_d    = tx_cnt;
    tx_bit_d    = tx_bit;
    tx_data_d   = tx_data;
    tx_bit_done = (tx_cnt == BIT_LAST);
    if (tx_state != TX_IDLE) tx_cnt_d = tx_bit_done ? '0 : tx_cnt + CNT_W'(1);
    case (tx_state)
      TX_IDLE: begin
        if (btn_rise || sw_on) begin
          tx_state_d = TX_START;
          tx_data_d  = ui_in;
          tx_cnt_d   = '0;
        end
      end
      TX_START: begin
        if (tx_bit_done) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_bit_done) begin
          tx_bit_d = tx_bit + 3'd1;
          if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_done) tx_state_d = TX_STOP;
      end
`endif
      // Continuous mode chains straight into the next start bit so no idle time appears between frames.
      TX_STOP: begin
        if (tx_bit_done) begin
          if (sw_on) begin
            tx_state_d = TX_START;
            tx_data_d  = ui_in;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Decoded straight from the state register so an asynchronous reset drives the line high at once.
  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_data[tx_bit];
`ifdef UART_PARITY_EN
      TX_PARITY: txd = even_parity(tx_data);
`endif
      default:   txd = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state != TX_IDLE);

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_frame_err)
  );

  always_comb begin
    uio_out               = '0;
    uio_out[TXD_BIT]      = txd;
    uio_out[RX_VALID_BIT] = rx_valid;
    uio_out[TX_BUSY_BIT]  = tx_busy;
    uio_out[RX_FERR_BIT]  = rx_frame_err;
  end

  assign uio_oe = UIO_OE_MASK;
  assign uo_out = rx_data;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_uart_transciver.sv
`timescale 1ns/1ps
`default_nettype none
// tb_tt_um_uart_transciver: directed TX/RX stimulus checked every cycle against a frame-level model.
module tb_tt_um_uart_transciver;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h04;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic       txd, rx_valid, tx_busy, rx_ferr;

  tt_um_uart_transciver #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  assign txd      = uio_out[3];
  assign rx_valid = uio_out[4];
  assign tx_busy  = uio_out[5];
  assign rx_ferr  = uio_out[6];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: bytes queued for TX, receive events queued for RX.
  typedef struct {
    logic [7:0] data;
    bit         good;
  } rx_ev_t;

  logic [7:0] tx_q[$];
  rx_ev_t     rx_q[$];
  int         tx_pos = -1;
  int         idle_run = 0;
  int         last_gap = -1;
  int         frames_started = 0;
  int         valid_count = 0;
  logic [9:0] tx_frame;
  logic [7:0] exp_uo = 8'h00;
  logic       exp_err = 1'b0;

  task automatic expect_rx(input logic [7:0] b, input bit good);
    rx_ev_t ev;
    ev.data = b;
    ev.good = good;
    rx_q.push_back(ev);
  endtask

  always @(negedge clk) begin
    rx_ev_t     ev;
    logic [7:0] b;
    if (!rst_n) begin
      chk("reset_uo_out", uo_out, 8'h00);
      chk("reset_uio_out", uio_out, 8'h08);
      chk("reset_uio_oe", uio_oe, 8'h78);
      tx_pos   = -1;
      idle_run = 0;
      tx_q.delete();
      rx_q.delete();
      exp_uo   = 8'h00;
      exp_err  = 1'b0;
    end else begin
      chk("uio_oe", uio_oe, 8'h78);
      chk("uio_out_unused_bits", uio_out & 8'h87, 8'h00);
      if (tx_pos < 0 && txd == 1'b0) begin
        chk("tx_frame_expected", tx_q.size() != 0, 1);
        b = 8'h00;
        if (tx_q.size() != 0) b = tx_q.pop_front();
        tx_frame = {1'b1, b, 1'b0};
        last_gap = idle_run;
        frames_started++;
        tx_pos = 0;
      end
      if (tx_pos >= 0) begin
        chk("txd_frame_bit", txd, tx_frame[tx_pos / CPB]);
        chk("tx_busy_in_frame", tx_busy, 1);
        idle_run = 0;
        tx_pos++;
        if (tx_pos == FRAME_CYC) tx_pos = -1;
      end else begin
        chk("txd_idle", txd, 1);
        chk("tx_busy_idle", tx_busy, 0);
        idle_run++;
      end
      if (rx_valid) begin
        valid_count++;
        chk("rx_valid_expected", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          ev = rx_q.pop_front();
          chk("rx_frame_is_good", ev.good, 1);
          chk("rx_uo_out_loaded", uo_out, ev.data);
          exp_uo = ev.data;
        end
        chk("rx_ferr_cleared", rx_ferr, 0);
        exp_err = 1'b0;
      end else if (rx_ferr && !exp_err) begin
        chk("rx_ferr_expected", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
          ev = rx_q.pop_front();
          chk("rx_frame_is_bad", ev.good, 0);
        end
        chk("rx_uo_out_kept_on_err", uo_out, exp_uo);
        exp_err = 1'b1;
      end else begin
        chk("rx_uo_out", uo_out, exp_uo);
        chk("rx_frame_err", rx_ferr, exp_err);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uio_in[2] = f[i];
      tick(CPB);
    end
    uio_in[2] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base, vbase, lat, busy_cycles;
    logic [9:0] seq;

    tick(4);
    chk("reset_uio_out_lit", uio_out, 8'h08);
    chk("reset_uo_out_lit", uo_out, 8'h00);
    chk("reset_uio_oe_lit", uio_oe, 8'h78);
    rst_n = 1'b1;
    tick(6);

    // Single send of 0xC9, ui_in disturbed mid-frame.
    ui_in = 8'hC9;
    tx_q.push_back(8'hC9);
    base = frames_started;
    uio_in[0] = 1'b1;
    lat = 0;
    while (txd && lat < 8) begin
      tick(1);
      lat++;
    end
    chk("tx_start_latency_le3", lat <= 3, 1);
    uio_in[0] = 1'b0;
    seq = '0;
    busy_cycles = 0;
    for (int c = 0; c < FRAME_CYC + 8; c++) begin
      if (c % CPB == 1 && c < FRAME_CYC) seq[c / CPB] = txd;
      busy_cycles += int'(tx_busy);
      if (c == 20) ui_in = 8'h00;
      tick(1);
    end
    chk("tx_seq_c9", seq, 10'b11_1001_0010);
    chk("tx_busy_cycles", busy_cycles, 40);
    chk("tx_single_frame", frames_started - base, 1);

    // Continuous mode: two back-to-back 0xA5 frames.
    ui_in = 8'hA5;
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'hA5);
    base = frames_started;
    uio_in[1] = 1'b1;
    for (int i = 0; i < 150 && (frames_started - base) < 2; i++) tick(1);
    ui_in = 8'h00;
    uio_in[1] = 1'b0;
    chk("cont_two_frames_started", frames_started - base, 2);
    chk("cont_no_idle_gap", last_gap, 0);
    tick(FRAME_CYC + 30);
    chk("cont_frames_total", frames_started - base, 2);
    chk("cont_txd_high_after", txd, 1);
    chk("cont_tx_q_empty", tx_q.size(), 0);

    // Receive 0x3C, then a one-cycle glitch.
    vbase = valid_count;
    expect_rx(8'h3C, 1'b1);
    send_rx(8'h3C, 1'b1);
    tick(12);
    chk("rx_3c_consumed", rx_q.size(), 0);
    chk("rx_3c_uo_out", uo_out, 8'h3C);
    chk("rx_3c_one_pulse", valid_count - vbase, 1);
    uio_in[2] = 1'b0;
    tick(1);
    uio_in[2] = 1'b1;
    tick(30);
    chk("rx_glitch_no_valid", valid_count - vbase, 1);
    chk("rx_glitch_uo_kept", uo_out, 8'h3C);

    // Framing error on 0x55, then good 0x12 received while 0x5A transmits.
    expect_rx(8'h55, 1'b0);
    send_rx(8'h55, 1'b0);
    tick(12);
    chk("ferr_uo_kept", uo_out, 8'h3C);
    chk("ferr_set", rx_ferr, 1);
    chk("ferr_consumed", rx_q.size(), 0);
    tick(20);
    chk("ferr_sticky", rx_ferr, 1);
    expect_rx(8'h12, 1'b1);
    ui_in = 8'h5A;
    tx_q.push_back(8'h5A);
    base = frames_started;
    fork
      send_rx(8'h12, 1'b1);
      begin
        uio_in[0] = 1'b1;
        tick(2);
        uio_in[0] = 1'b0;
      end
    join
    tick(50);
    chk("rx_12_uo_out", uo_out, 8'h12);
    chk("rx_12_ferr_cleared", rx_ferr, 0);
    chk("rx_12_consumed", rx_q.size(), 0);
    chk("dual_tx_frame", frames_started - base, 1);
    chk("dual_tx_q_empty", tx_q.size(), 0);

    // Reset asserted mid-frame.
    ui_in = 8'hF0;
    tx_q.push_back(8'hF0);
    uio_in[0] = 1'b1;
    tick(2);
    uio_in[0] = 1'b0;
    for (int i = 0; i < 10 && !tx_busy; i++) tick(1);
    tick(10);
    chk("abort_txd_low_before", txd, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txd_async_high", txd, 1);
    chk("abort_busy_cleared", tx_busy, 0);
    chk("abort_uo_cleared", uo_out, 8'h00);
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Button pressed again while busy: exactly one frame.
    ui_in = 8'h3A;
    tx_q.push_back(8'h3A);
    base = frames_started;
    uio_in[0] = 1'b1;
    tick(2);
    uio_in[0] = 1'b0;
    for (int i = 0; i < 10 && !tx_busy; i++) tick(1);
    tick(8);
    uio_in[0] = 1'b1;
    tick(3);
    uio_in[0] = 1'b0;
    for (int i = 0; i < 100 && tx_busy; i++) tick(1);
    chk("collision_tx_idle", tx_busy, 0);
    tick(20);
    chk("collision_one_frame", frames_started - base, 1);
    chk("collision_q_empty", tx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_um_uart_transciver.md
TT_UM_UART_TRANSCIVER -- requirements
Module: tt_um_uart_transciver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (115200 baud at 100 MHz); legal range 4..4095.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ena, input, 1, tile enable; ignored by logic.
REQ-005 SHALL have port ui_in, input, 8, the byte to transmit.
REQ-006 SHALL have port uo_out, output, 8, the last correctly received byte.
REQ-007 SHALL have port uio_in, input, 8: bit0 Transmit_btn, bit1 Transmit_switch, bit2 uart_rxd; bits 7:3 unused.
REQ-008 SHALL have port uio_out, output, 8: bit3 uart_txd, bit4 rx_valid, bit5 tx_busy, bit6 rx_frame_err; all other bits 0.
REQ-009 SHALL have port uio_oe, output, 8, constant 8'b0111_1000.

Function
REQ-010 SHALL pass uio_in[0], uio_in[1] and uio_in[2] each through a 2-flop synchronizer before use.
REQ-011 SHALL use 8N1 framing, LSB first, idle line high, for both TX and RX.
REQ-012 TX FSM SHALL have states IDLE, START, DATA, STOP, each bit lasting exactly CLKS_PER_BIT cycles.
REQ-013 In IDLE, a rising edge of synced Transmit_btn SHALL latch ui_in and enter START, with txd falling no more than 3 cycles after uio_in[0] rises.
REQ-014 While synced Transmit_switch is 1, TX SHALL leave IDLE on the next cycle, latching ui_in, so frames repeat back-to-back.
REQ-015 Button edges arriving while not in IDLE SHALL be ignored.
REQ-016 Changes to ui_in or the switch during a frame SHALL NOT affect the frame in progress.
REQ-017 tx_busy SHALL be 1 in every state except IDLE.
REQ-018 RX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 RX SHALL leave IDLE on a falling edge of synced rxd.
REQ-020 RX SHALL re-sample rxd at CLKS_PER_BIT/2 and return to IDLE if it is 1 (glitch reject).
REQ-021 RX SHALL then sample each data bit and the stop bit at mid-bit.
REQ-022 If the stop bit samples 1, RX SHALL load uo_out, pulse rx_valid for exactly 1 cycle in that same cycle, and clear rx_frame_err.
REQ-023 If the stop bit samples 0, RX SHALL leave uo_out unchanged, set rx_frame_err (sticky until the next good frame), and wait for rxd high before re-arming.
REQ-024 TX and RX SHALL operate independently and simultaneously.

Reset
REQ-025 While rst_n is 0: both FSMs SHALL be in IDLE, uo_out 0, txd 1, rx_valid 0, tx_busy 0, rx_frame_err 0, all counters 0, synchronizers 1 for rxd and 0 for the other inputs.
REQ-026 Reset asserted mid-frame SHALL force txd high immediately (asynchronously) and abort any RX frame.

Configuration
REQ-027 If UART_PARITY_EN is defined, TX SHALL insert an even-parity bit (PARITY state) between DATA and STOP, and RX SHALL check it.
REQ-028 With UART_PARITY_EN defined, a parity mismatch SHALL be treated exactly like a framing error (REQ-023).
REQ-029 If UART_PARITY_EN is undefined, there SHALL be no PARITY state and the frame is 10 bits.

Structure
REQ-030 Package uart_pkg SHALL hold the TX/RX state enums, default CLKS_PER_BIT, and the uio bit-index constants.
REQ-031 The receiver SHALL be one sub-module, uart_rx; the TX FSM, synchronizers and pin mapping SHALL live in the top level.

Verification (bench uses CLKS_PER_BIT=4)
REQ-032 Reset check: hold rst_n=0 -> uo_out=0x00, uio_out=0x08, uio_oe=0x78.
REQ-033 Single send: ui_in=0xC9, pulse uio_in[0] -> txd sequence 0,1,0,0,1,0,0,1,1,1 (4 cycles per bit); tx_busy=1 for 40 cycles, then 0.
REQ-034 Continuous send: uio_in[1]=1, ui_in=0xA5 -> two back-to-back frames with no idle bit; after clearing the switch, the current frame ends and txd stays 1.
REQ-035 Receive: drive 0x3C on uio_in[2] -> uo_out=0x3C and one rx_valid pulse; a 1-cycle low glitch -> no rx_valid.
REQ-036 Framing error: send 0x55 with stop=0 -> uo_out unchanged and rx_frame_err=1; then a good 0x12 -> uo_out=0x12 and rx_frame_err=0.
REQ-037 Abort and collision: assert rst_n=0 mid-TX -> txd=1 at once; pressing the button while busy -> exactly one frame sent.
